// File: rtl/img_out_reader_if.sv
// rtl/img_out_reader_if.sv - data-memory read port and pixel stream bundle for img_out_reader
//
// Purpose: groups the data-memory read bus and the pixel output stream.
// Ports (signals):
//   mem_address_o  32     read address toward data memory
//   mem_rd_o       1      one-cycle read strobe
//   mem_data_i     32     read data, valid one cycle after mem_rd_o
//   pix_data_o     8      pixel byte
//   pix_valid_o    1      pixel available
//   pix_ready_i    1      consumer accepts pixel
//   pix_last_o     1      final pixel of the transfer
//   pix_index_o    CNT_W  0-based pixel index
// Modports: master = the reader, slave = memory plus pixel consumer.
interface img_out_reader_if #(
    parameter int CNT_W = 17
);
    logic [31:0]      mem_address_o;
    logic             mem_rd_o;
    logic [31:0]      mem_data_i;
    logic [7:0]       pix_data_o;
    logic             pix_valid_o;
    logic             pix_ready_i;
    logic             pix_last_o;
    logic [CNT_W-1:0] pix_index_o;

    modport master (
        output mem_address_o, mem_rd_o, pix_data_o, pix_valid_o, pix_last_o, pix_index_o,
        input  mem_data_i, pix_ready_i
    );

    modport slave (
        input  mem_address_o, mem_rd_o, pix_data_o, pix_valid_o, pix_last_o, pix_index_o,
        output mem_data_i, pix_ready_i
    );
endinterface

// File: rtl/img_out_reader.sv
// rtl/img_out_reader.sv - read-back engine streaming the output image region as pixels
//
// Purpose: on start, reads data memory words at BASE_ADDR + index one at a time
// and presents the low byte of each as a pixel on a valid/ready stream.
// Ports:
//   CLK, RST   clock (rising edge) and synchronous active-high reset
//   start_i    begin a transfer (ignored unless idle)
//   length_i   pixel count, clamped to MAX_LEN
//   abort_i    terminate an active transfer, no done pulse
//   bus        img_out_reader_if.master: memory read port + pixel stream
//   busy_o     transfer in progress (REQ/WAIT/SEND)
//   done_o     one-cycle pulse after the last pixel is accepted
module img_out_reader #(
    parameter logic [31:0] BASE_ADDR = 32'd262144,
    parameter int          MAX_LEN   = 65536,
    parameter int          CNT_W     = $clog2(MAX_LEN) + 1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               start_i,
    input  logic [CNT_W-1:0]   length_i,
    input  logic               abort_i,
    img_out_reader_if.master   bus,
    output logic               busy_o,
    output logic               done_o
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        SEND = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] MAX_LEN_C = CNT_W'(MAX_LEN);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic [31:0]       addr_q, addr_d;
    logic              rd_q, rd_d;
    logic [7:0]        pix_data_q, pix_data_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [CNT_W-1:0]  idx_inc;
    logic              unused_mem_hi;

    // Only the low byte of each memory word carries a pixel.
    assign unused_mem_hi = ^bus.mem_data_i[31:8];
    assign idx_inc       = idx_q + CNT_W'(1);

    // All outputs are registered: each *_d is the value the output takes in
    // the state being entered, so outputs line up with the state register.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        len_d      = len_q;
        addr_d     = addr_q;
        rd_d       = 1'b0;
        pix_data_d = pix_data_q;
        valid_d    = 1'b0;
        last_d     = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                // start beats a simultaneous abort here since abort only acts when busy
                if (start_i) begin
                    len_d = (length_i > MAX_LEN_C) ? MAX_LEN_C : length_i;
                    idx_d = '0;
                    if (length_i == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = REQ;
                        rd_d    = 1'b1;
                        addr_d  = BASE_ADDR;
                        busy_d  = 1'b1;
                    end
                end
            end
            REQ: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT;
                    busy_d  = 1'b1;
                end
            end
            WAIT: begin
                // Read data lands this cycle; on abort it is simply not captured.
                if (abort_i) begin
                    state_d = IDLE;
                end else begin
                    state_d    = SEND;
                    pix_data_d = bus.mem_data_i[7:0];
                    valid_d    = 1'b1;
                    last_d     = (idx_q == len_q - CNT_W'(1));
                    busy_d     = 1'b1;
                end
            end
            SEND: begin
                if (abort_i) begin
                    // abort wins over a same-cycle handshake
                    state_d = IDLE;
                end else if (bus.pix_ready_i) begin
                    if (last_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = REQ;
                        idx_d   = idx_inc;
                        rd_d    = 1'b1;
                        addr_d  = BASE_ADDR + {{(32-CNT_W){1'b0}}, idx_inc};
                        busy_d  = 1'b1;
                    end
                end else begin
                    valid_d = 1'b1;
                    last_d  = last_q;
                    busy_d  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            len_q      <= '0;
            addr_q     <= '0;
            rd_q       <= 1'b0;
            pix_data_q <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            len_q      <= len_d;
            addr_q     <= addr_d;
            rd_q       <= rd_d;
            pix_data_q <= pix_data_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.mem_address_o = addr_q;
    assign bus.mem_rd_o      = rd_q;
    assign bus.pix_data_o    = pix_data_q;
    assign bus.pix_valid_o   = valid_q;
    assign bus.pix_last_o    = last_q;
    assign bus.pix_index_o   = idx_q;
    assign busy_o            = busy_q;
    assign done_o            = done_q;

endmodule

// File: tb/tb_img_out_reader.sv
// tb/tb_img_out_reader.sv - directed self-checking bench for img_out_reader
module tb_img_out_reader;

    localparam logic [31:0] BASE  = 32'd262144;
    localparam int          CNT_W = 17;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             start_i = 1'b0;
    logic [CNT_W-1:0] length_i = '0;
    logic             abort_i = 1'b0;
    logic             busy_o;
    logic             done_o;

    img_out_reader_if #(.CNT_W(CNT_W)) bus ();

    img_out_reader #(.BASE_ADDR(BASE), .MAX_LEN(65536), .CNT_W(CNT_W)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .start_i  (start_i),
        .length_i (length_i),
        .abort_i  (abort_i),
        .bus      (bus),
        .busy_o   (busy_o),
        .done_o   (done_o)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    bit          use_const = 1'b0;
    logic [31:0] const_word = 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return use_const ? const_word : (a - BASE + 32'd16);
    endfunction

    // Memory returns data one cycle after the strobe; garbage otherwise.
    initial bus.mem_data_i = 32'h5555_55EE;
    always @(posedge CLK)
        bus.mem_data_i <= bus.mem_rd_o ? mem_word(bus.mem_address_o) : 32'h5555_55EE;

    // Monitor (samples pre-edge values at each rising edge)
    int          cyc = 0;
    int          rd_cnt = 0, done_cnt = 0, valid_cnt = 0, busy_cnt = 0;
    int          hs_cyc = 0, done_cyc = 0;
    logic [31:0] rd_addr[$];
    logic [7:0]  pix_q[$];
    int          pidx_q[$];
    bit          plast_q[$];

    always @(posedge CLK) begin
        cyc++;
        if (!RST) begin
            if (bus.mem_rd_o) begin rd_cnt++; rd_addr.push_back(bus.mem_address_o); end
            if (bus.pix_valid_o && bus.pix_ready_i && !abort_i) begin
                pix_q.push_back(bus.pix_data_o);
                pidx_q.push_back(int'(bus.pix_index_o));
                plast_q.push_back(bus.pix_last_o);
                hs_cyc = cyc;
            end
            if (done_o) begin done_cnt++; done_cyc = cyc; end
            if (bus.pix_valid_o) valid_cnt++;
            if (busy_o) busy_cnt++;
        end
    end

    task automatic clear_mon();
        rd_cnt = 0; done_cnt = 0; valid_cnt = 0; busy_cnt = 0;
        rd_addr.delete(); pix_q.delete(); pidx_q.delete(); plast_q.delete();
    endtask

    task automatic do_start(input int len);
        @(negedge CLK); start_i = 1'b1; length_i = CNT_W'(len);
        @(negedge CLK); start_i = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (done_o) begin ok = 1'b1; return; end
            @(negedge CLK);
        end
    endtask

    task automatic wait_valid_idx(input int idx, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus.pix_valid_o && int'(bus.pix_index_o) == idx) begin ok = 1'b1; return; end
            @(negedge CLK);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1; bus.pix_ready_i = 1'b0;
        repeat (3) @(negedge CLK);
        checks++; if (busy_o !== 1'b0 || done_o !== 1'b0) begin errors++; $display("FAIL reset_busy_done: got %b%b want 00", busy_o, done_o); end
        checks++; if (bus.mem_rd_o !== 1'b0 || bus.mem_address_o !== 32'h0) begin errors++; $display("FAIL reset_mem: got rd=%b addr=%h want 0/0", bus.mem_rd_o, bus.mem_address_o); end
        checks++; if (bus.pix_valid_o !== 1'b0 || bus.pix_last_o !== 1'b0 || bus.pix_data_o !== 8'h0 || bus.pix_index_o !== '0) begin
            errors++; $display("FAIL reset_pix: got v=%b l=%b d=%h i=%0d want zeros", bus.pix_valid_o, bus.pix_last_o, bus.pix_data_o, bus.pix_index_o); end
        RST = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_basic();
        bit ok;
        clear_mon(); bus.pix_ready_i = 1'b1;
        @(negedge CLK); start_i = 1'b1; length_i = CNT_W'(4);
        @(negedge CLK); start_i = 1'b0;
        checks++; if (bus.mem_rd_o !== 1'b1 || bus.mem_address_o !== BASE || busy_o !== 1'b1 || bus.pix_valid_o !== 1'b0) begin
            errors++; $display("FAIL basic_req: got rd=%b addr=%0d busy=%b v=%b want 1/262144/1/0", bus.mem_rd_o, bus.mem_address_o, busy_o, bus.pix_valid_o); end
        @(negedge CLK);
        checks++; if (bus.mem_rd_o !== 1'b0 || bus.pix_valid_o !== 1'b0 || bus.mem_address_o !== BASE) begin
            errors++; $display("FAIL basic_wait: got rd=%b v=%b addr=%0d want 0/0/262144", bus.mem_rd_o, bus.pix_valid_o, bus.mem_address_o); end
        @(negedge CLK);
        checks++; if (bus.pix_valid_o !== 1'b1 || bus.pix_data_o !== 8'd16 || bus.pix_index_o !== '0 || bus.pix_last_o !== 1'b0) begin
            errors++; $display("FAIL basic_first_pix: got v=%b d=%0d i=%0d l=%b want 1/16/0/0", bus.pix_valid_o, bus.pix_data_o, bus.pix_index_o, bus.pix_last_o); end
        wait_done(ok);
        checks++; if (!ok) begin errors++; $display("FAIL basic_done_timeout: got no done want done"); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL basic_busy_in_done: got %b want 0", busy_o); end
        repeat (3) @(negedge CLK);
        checks++; if (pix_q.size() != 4) begin errors++; $display("FAIL basic_count: got %0d want 4", pix_q.size()); end
        for (int k = 0; k < pix_q.size() && k < 4; k++) begin
            checks++; if (pix_q[k] !== 8'(16 + k) || pidx_q[k] != k || plast_q[k] !== (k == 3)) begin
                errors++; $display("FAIL basic_pix%0d: got d=%0d i=%0d l=%b want %0d/%0d/%b", k, pix_q[k], pidx_q[k], plast_q[k], 16 + k, k, k == 3); end
        end
        checks++; if (rd_cnt != 4) begin errors++; $display("FAIL basic_rd_cnt: got %0d want 4", rd_cnt); end
        for (int k = 0; k < rd_addr.size() && k < 4; k++) begin
            checks++; if (rd_addr[k] !== BASE + 32'(k)) begin errors++; $display("FAIL basic_addr%0d: got %0d want %0d", k, rd_addr[k], BASE + 32'(k)); end
        end
        checks++; if (done_cnt != 1 || done_cyc != hs_cyc + 1) begin
            errors++; $display("FAIL basic_done_pulse: got cnt=%0d cyc=%0d want 1/%0d", done_cnt, done_cyc, hs_cyc + 1); end
    endtask

    task automatic test_backpressure();
        bit ok;
        clear_mon(); bus.pix_ready_i = 1'b1;
        do_start(3);
        wait_valid_idx(1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_reach_pix1: got timeout want pixel 1"); end
        bus.pix_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            checks++; if (bus.pix_valid_o !== 1'b1 || bus.pix_data_o !== 8'd17 || bus.pix_index_o !== CNT_W'(1) || bus.pix_last_o !== 1'b0) begin
                errors++; $display("FAIL bp_hold%0d: got v=%b d=%0d i=%0d l=%b want 1/17/1/0", i, bus.pix_valid_o, bus.pix_data_o, bus.pix_index_o, bus.pix_last_o); end
        end
        @(negedge CLK);
        checks++; if (rd_cnt != 2 || bus.pix_data_o !== 8'd17) begin errors++; $display("FAIL bp_no_extra_rd: got rd=%0d d=%0d want 2/17", rd_cnt, bus.pix_data_o); end
        bus.pix_ready_i = 1'b1;
        wait_done(ok);
        repeat (2) @(negedge CLK);
        checks++; if (!ok || pix_q.size() != 3 || rd_cnt != 3 || done_cnt != 1) begin
            errors++; $display("FAIL bp_complete: got ok=%b pix=%0d rd=%0d done=%0d want 1/3/3/1", ok, pix_q.size(), rd_cnt, done_cnt); end
        for (int k = 0; k < pix_q.size() && k < 3; k++) begin
            checks++; if (pix_q[k] !== 8'(16 + k) || pidx_q[k] != k) begin errors++; $display("FAIL bp_pix%0d: got %0d/%0d want %0d/%0d", k, pix_q[k], pidx_q[k], 16 + k, k); end
        end
    endtask

    task automatic test_zero_length();
        clear_mon(); bus.pix_ready_i = 1'b1;
        do_start(0);
        checks++; if (done_o !== 1'b1 || busy_o !== 1'b0) begin errors++; $display("FAIL zero_done: got done=%b busy=%b want 1/0", done_o, busy_o); end
        @(negedge CLK);
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL zero_done_pulse: got %b want 0", done_o); end
        repeat (3) @(negedge CLK);
        checks++; if (rd_cnt != 0 || valid_cnt != 0 || busy_cnt != 0 || done_cnt != 1) begin
            errors++; $display("FAIL zero_quiet: got rd=%0d v=%0d busy=%0d done=%0d want 0/0/0/1", rd_cnt, valid_cnt, busy_cnt, done_cnt); end
    endtask

    task automatic test_abort();
        bit ok;
        clear_mon(); bus.pix_ready_i = 1'b1;
        do_start(10);
        wait_valid_idx(2, ok);
        checks++; if (!ok) begin errors++; $display("FAIL abort_reach_pix2: got timeout want pixel 2"); end
        abort_i = 1'b1;
        @(negedge CLK); abort_i = 1'b0;
        checks++; if (bus.pix_valid_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL abort_drop: got v=%b busy=%b want 0/0", bus.pix_valid_o, busy_o); end
        repeat (4) @(negedge CLK);
        checks++; if (done_cnt != 0 || pix_q.size() != 2 || rd_cnt != 3) begin
            errors++; $display("FAIL abort_counts: got done=%0d pix=%0d rd=%0d want 0/2/3", done_cnt, pix_q.size(), rd_cnt); end
        clear_mon();
        do_start(2);
        wait_done(ok);
        repeat (2) @(negedge CLK);
        checks++; if (!ok || pix_q.size() != 2 || done_cnt != 1) begin
            errors++; $display("FAIL abort_restart: got ok=%b pix=%0d done=%0d want 1/2/1", ok, pix_q.size(), done_cnt); end
        for (int k = 0; k < pix_q.size() && k < 2; k++) begin
            checks++; if (pix_q[k] !== 8'(16 + k) || pidx_q[k] != k || plast_q[k] !== (k == 1)) begin
                errors++; $display("FAIL abort_restart_pix%0d: got %0d/%0d/%b want %0d/%0d/%b", k, pix_q[k], pidx_q[k], plast_q[k], 16 + k, k, k == 1); end
        end
    endtask

    task automatic test_reset_mid();
        clear_mon(); bus.pix_ready_i = 1'b1;
        do_start(4);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        checks++; if (busy_o !== 1'b0 || done_o !== 1'b0 || bus.mem_rd_o !== 1'b0 || bus.mem_address_o !== 32'h0 ||
                      bus.pix_valid_o !== 1'b0 || bus.pix_data_o !== 8'h0 || bus.pix_index_o !== '0 || bus.pix_last_o !== 1'b0) begin
            errors++; $display("FAIL rst_mid: got busy=%b done=%b rd=%b addr=%h v=%b d=%h i=%0d l=%b want all 0", busy_o, done_o,
                bus.mem_rd_o, bus.mem_address_o, bus.pix_valid_o, bus.pix_data_o, bus.pix_index_o, bus.pix_last_o); end
        RST = 1'b0;
        repeat (4) @(negedge CLK);
        checks++; if (busy_o !== 1'b0 || bus.pix_valid_o !== 1'b0) begin errors++; $display("FAIL rst_stays_idle: got busy=%b v=%b want 0/0", busy_o, bus.pix_valid_o); end
    endtask

    task automatic test_start_ignored();
        bit ok;
        clear_mon(); bus.pix_ready_i = 1'b1;
        do_start(4);
        wait_valid_idx(1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL ign_reach_pix1: got timeout want pixel 1"); end
        start_i = 1'b1; length_i = CNT_W'(1);
        @(negedge CLK); start_i = 1'b0;
        wait_done(ok);
        repeat (2) @(negedge CLK);
        checks++; if (!ok || pix_q.size() != 4 || rd_cnt != 4 || done_cnt != 1) begin
            errors++; $display("FAIL ign_counts: got ok=%b pix=%0d rd=%0d done=%0d want 1/4/4/1", ok, pix_q.size(), rd_cnt, done_cnt); end
        for (int k = 0; k < pix_q.size() && k < 4; k++) begin
            checks++; if (pix_q[k] !== 8'(16 + k) || pidx_q[k] != k || plast_q[k] !== (k == 3)) begin
                errors++; $display("FAIL ign_pix%0d: got %0d/%0d/%b want %0d/%0d/%b", k, pix_q[k], pidx_q[k], plast_q[k], 16 + k, k, k == 3); end
        end
    endtask

    task automatic test_width();
        bit ok;
        clear_mon(); bus.pix_ready_i = 1'b0;
        use_const = 1'b1; const_word = 32'hDEAD_BEA5;
        do_start(1);
        wait_valid_idx(0, ok);
        checks++; if (!ok || bus.pix_data_o !== 8'hA5 || bus.pix_last_o !== 1'b1) begin
            errors++; $display("FAIL width_data: got ok=%b d=%h l=%b want 1/a5/1", ok, bus.pix_data_o, bus.pix_last_o); end
        bus.pix_ready_i = 1'b1;
        wait_done(ok);
        repeat (2) @(negedge CLK);
        checks++; if (!ok || done_cnt != 1 || rd_cnt != 1) begin errors++; $display("FAIL width_done: got ok=%b done=%0d rd=%0d want 1/1/1", ok, done_cnt, rd_cnt); end
        use_const = 1'b0;
    endtask

    initial begin
        bus.pix_ready_i = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_length();
        test_abort();
        test_reset_mid();
        test_start_ignored();
        test_width();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
